instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Automatic instruction issuer for the switch-driven processor datapath. Holds a small program RAM of packed instructions and plays them into the processor's instruction/operand latches and execute/compare strobes, taking the place of the operator toggling switches and keys. Sits between a program loader and the processor core, with one ack per issued instruction and optional single-step.

## Interface
Parameters:
- DEPTH, 16: program words; power of two, 2..256. PW = $clog2(DEPTH).
- TIMEOUT, 255: max cycles in WAIT without ack before error; 1..255.

Ports:
- CLOCK_50  in  1  sole clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- prog_we  in  1  program write strobe; honoured only in IDLE or HALT.
- prog_addr  in  PW  program write address.
- prog_data  in  12  word {op[11:9], dr[8:6], sr1[5:3], sr2[2:0]}.
- start  in  1  begin run at address 0; honoured only in IDLE or HALT.
- abort  in  1  return to IDLE from any state.
- step_mode  in  1  1 = pause after each instruction.
- step  in  1  resume from PAUSE.
- ack  in  1  processor finished current instruction.
- inst_out  out  3  opcode to processor instruction latch.
- dr_out, sr1_out, sr2_out  out  3 each  operand fields.
- ld_pulse  out  1  one-cycle load of inst/operand latches.
- exec_pulse  out  1  one-cycle execute (ops 001, 010, 011, 110).
- cmp_pulse  out  1  one-cycle compare (op 101).
- busy  out  1  high in any state except IDLE and HALT.
- done  out  1  normal completion flag.
- err  out  1  illegal opcode or ack timeout.
- pc  out  PW  address of current/last instruction.

## Operation
- Opcodes: 000 halt; 001 load; 010 add; 011 mul; 101 compare; 110 store; 100, 111 illegal.
- Program RAM: DEPTH x 12, synchronous read; written with prog_data at prog_addr on prog_we. Not cleared by RESET.
- States: IDLE, FETCH, DECODE, LOAD, FIRE, WAIT, PAUSE, HALT.
- IDLE: start -> pc=0, clear done/err, FETCH.
- FETCH: RAM read at pc issued -> DECODE.
- DECODE: word captured into inst/dr/sr1/sr2 output registers. op 000 -> HALT, done=1. op 100/111 -> HALT, err=1. Else -> LOAD.
- LOAD: ld_pulse=1 -> FIRE.
- FIRE: exec_pulse=1 or cmp_pulse=1 per op -> WAIT; timeout counter cleared.
- WAIT: ack=1 -> if pc==DEPTH-1: HALT, done=1; else pc+1, then PAUSE if step_mode else FETCH. Counter reaching TIMEOUT without ack -> HALT, err=1, pc unchanged.
- PAUSE: step=1 -> FETCH.
- HALT: done/err, pc, operand outputs held; start restarts from 0.
- Priority: RESET > abort > all else. abort -> IDLE, done=err=0, pc kept. ack outside WAIT ignored. start/prog_we outside IDLE/HALT ignored. step outside PAUSE ignored.

## Timing
- Reset values: all outputs 0, state IDLE.
- Pulses are registered Moore outputs, exactly one cycle wide.
- start sampled at edge N: ld_pulse high in cycle after edge N+3, exec/cmp_pulse one cycle later.
- ack may already be high in first WAIT cycle; sampled there gives minimum 5 cycles per instruction (FETCH..WAIT).
- Operand/inst outputs stable from LOAD through end of WAIT.
- Timeout: err asserted after TIMEOUT WAIT cycles with ack low; ack on the same edge the counter hits TIMEOUT wins.
- RESET mid-run: next cycle IDLE, no further pulses; program RAM intact.
- prog_we same cycle as start in IDLE: write lands, run starts; write to address 0 is read by FETCH.

## Test plan
- Load {001,001,000,000}, {001,010,001,000}, {010,011,001,010}, halt; start, ack tied 1 -> ld/exec pulses at 3 instructions, 5 cycles apart, done=1, pc=3, err=0.
- Word op=101 dr=0 sr1=2 sr2=3 -> cmp_pulse once, exec_pulse never; inst_out=101, sr1_out=2, sr2_out=3.
- Word op=111 at addr 2 -> two instructions issued, HALT with err=1, pc=2, no pulses for addr 2.
- ack held 0, TIMEOUT=10 -> err=1 exactly 10 cycles after FIRE; ack on cycle 10 instead -> no err, next FETCH.
- step_mode=1 -> stops in PAUSE after each ack (busy=1, no pulses); step advances one instruction.
- Full DEPTH program without halt -> done after pc=DEPTH-1; abort during WAIT -> IDLE, busy=0; RESET mid-LOAD -> all outputs 0, rerun gives same result.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Processor-side bus of the instruction sequencer: instruction/operand latches,
// the load/execute/compare strobes and the per-instruction completion ack.
interface instr_sequencer_if;
    logic [2:0] inst_out;
    logic [2:0] dr_out;
    logic [2:0] sr1_out;
    logic [2:0] sr2_out;
    logic       ld_pulse;
    logic       exec_pulse;
    logic       cmp_pulse;
    logic       ack;

    modport master (
        output inst_out, dr_out, sr1_out, sr2_out,
        output ld_pulse, exec_pulse, cmp_pulse,
        input  ack
    );

    modport slave (
        input  inst_out, dr_out, sr1_out, sr2_out,
        input  ld_pulse, exec_pulse, cmp_pulse,
        output ack
    );
endinterface

// File: rtl/instr_sequencer.sv
// Plays a small program RAM of packed instructions into the processor latches,
// issuing one load/execute (or compare) strobe pair per word and waiting for ack.
//
// state  | meaning
// IDLE   | not running; program writes and start accepted
// FETCH  | RAM read at pc issued
// DECODE | word captured into operand registers, halt/illegal screened
// LOAD   | ld_pulse raised on the following cycle
// FIRE   | exec_pulse or cmp_pulse raised on the following cycle, timer loaded
// WAIT   | waiting for ack, timer counting down
// PAUSE  | single-step hold until step
// HALT   | run finished (done) or failed (err); outputs held
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              prog_we,
    input  logic [PW-1:0]     prog_addr,
    input  logic [11:0]       prog_data,
    input  logic              start,
    input  logic              abort,
    input  logic              step_mode,
    input  logic              step,
    instr_sequencer_if.master proc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PW-1:0]     pc
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_LOAD, S_FIRE, S_WAIT, S_PAUSE, S_HALT
    } state_t;

    localparam logic [7:0]    TMR_LOAD = 8'(TIMEOUT - 1);
    localparam logic [PW-1:0] PC_LAST  = PW'(DEPTH - 1);

    state_t      state;
    logic [7:0]  tmr;
    logic [11:0] ram [DEPTH];
    logic [11:0] rd_word;
    logic        prog_ok;

    assign prog_ok = (state == S_IDLE) || (state == S_HALT);

    // Program RAM survives RESET so a run can be repeated after a reset.
    always_ff @(posedge CLOCK_50) begin
        if (prog_we && prog_ok)
            ram[prog_addr] <= prog_data;
        if (state == S_FETCH)
            rd_word <= ram[pc];
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state           <= S_IDLE;
            tmr             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            pc              <= '0;
            proc.inst_out   <= '0;
            proc.dr_out     <= '0;
            proc.sr1_out    <= '0;
            proc.sr2_out    <= '0;
            proc.ld_pulse   <= 1'b0;
            proc.exec_pulse <= 1'b0;
            proc.cmp_pulse  <= 1'b0;
        end else begin
            proc.ld_pulse   <= 1'b0;
            proc.exec_pulse <= 1'b0;
            proc.cmp_pulse  <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                err   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_HALT: begin
                        if (start) begin
                            pc    <= '0;
                            done  <= 1'b0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: state <= S_DECODE;
                    S_DECODE: begin
                        {proc.inst_out, proc.dr_out, proc.sr1_out, proc.sr2_out} <= rd_word;
                        if (rd_word[11:9] == 3'b000) begin
                            state <= S_HALT;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (rd_word[11:9] == 3'b100 || rd_word[11:9] == 3'b111) begin
                            state <= S_HALT;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        proc.ld_pulse <= 1'b1;
                        state         <= S_FIRE;
                    end
                    S_FIRE: begin
                        // Only legal, non-halt opcodes reach here: compare or execute.
                        if (proc.inst_out == 3'b101)
                            proc.cmp_pulse <= 1'b1;
                        else
                            proc.exec_pulse <= 1'b1;
                        tmr   <= TMR_LOAD;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (proc.ack) begin
                            if (pc == PC_LAST) begin
                                state <= S_HALT;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                pc    <= pc + 1'b1;
                                state <= step_mode ? S_PAUSE : S_FETCH;
                            end
                        end else if (tmr == 8'd0) begin
                            state <= S_HALT;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            tmr <= tmr - 8'd1;
                        end
                    end
                    S_PAUSE: begin
                        if (step)
                            state <= S_FETCH;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs push expected strobes
// and end-of-run status; a negedge monitor pops and compares as the DUT emits them.
module tb_instr_sequencer;
    localparam int EV_LD  = 0;
    localparam int EV_EX  = 1;
    localparam int EV_CMP = 2;
    localparam int EV_END = 3;

    typedef struct {
        int         kind;
        logic [2:0] op, dr, sr1, sr2;
        int         pc;
        int         gap;
        logic       done, err;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [11:0] prog_data = '0;
    logic        start = 1'b0, abort = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic        busy, done, err;
    logic [3:0]  pc;

    instr_sequencer_if bus();

    instr_sequencer #(.DEPTH(16), .TIMEOUT(10)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .start    (start),
        .abort    (abort),
        .step_mode(step_mode),
        .step     (step),
        .proc     (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .pc       (pc)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    exp_t sbq[$];
    int   n_cmp = 0, n_mism = 0;
    int   cyc = 0, last_ld = 0, last_fire = 0, n_pulse = 0;
    logic busy_q = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mism++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_evt(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_mism++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
            return;
        end
        e = sbq.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == EV_END) begin
            chk("end_done", int'(done), int'(e.done));
            chk("end_err", int'(err), int'(e.err));
            chk("end_pc", int'(pc), e.pc);
            if (e.gap != 0) chk("end_gap", cyc - last_fire, e.gap);
        end else begin
            chk("inst_out", int'(bus.inst_out), int'(e.op));
            chk("dr_out", int'(bus.dr_out), int'(e.dr));
            chk("sr1_out", int'(bus.sr1_out), int'(e.sr1));
            chk("sr2_out", int'(bus.sr2_out), int'(e.sr2));
            chk("pulse_pc", int'(pc), e.pc);
            if (kind == EV_LD && e.gap != 0) chk("ld_gap", cyc - last_ld, e.gap);
        end
    endtask

    always @(negedge CLOCK_50) begin
        cyc++;
        if (bus.ld_pulse)   begin n_pulse++; check_evt(EV_LD);  last_ld = cyc;   end
        if (bus.exec_pulse) begin n_pulse++; check_evt(EV_EX);  last_fire = cyc; end
        if (bus.cmp_pulse)  begin n_pulse++; check_evt(EV_CMP); last_fire = cyc; end
        if (busy_q && !busy) check_evt(EV_END);
        busy_q = busy;
    end

    task automatic push_instr(input logic [11:0] w, input int p, input int gap);
        exp_t e;
        e.op = w[11:9]; e.dr = w[8:6]; e.sr1 = w[5:3]; e.sr2 = w[2:0];
        e.pc = p; e.done = 1'b0; e.err = 1'b0;
        e.kind = EV_LD; e.gap = gap;
        sbq.push_back(e);
        e.kind = (w[11:9] == 3'b101) ? EV_CMP : EV_EX; e.gap = 0;
        sbq.push_back(e);
    endtask

    task automatic push_end(input logic d, input logic er, input int p, input int gap);
        exp_t e;
        e.kind = EV_END; e.op = '0; e.dr = '0; e.sr1 = '0; e.sr2 = '0;
        e.pc = p; e.gap = gap; e.done = d; e.err = er;
        sbq.push_back(e);
    endtask

    task automatic load_word(input int a, input logic [11:0] w);
        prog_we = 1'b1; prog_addr = 4'(a); prog_data = w;
        @(negedge CLOCK_50);
        prog_we = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_fire(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge CLOCK_50);
            if (bus.exec_pulse || bus.cmp_pulse) return;
        end
        chk("wait_fire_timeout", 1, 0);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge CLOCK_50);
            if (!busy) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, int'({bus.inst_out, bus.dr_out, bus.sr1_out, bus.sr2_out}), 0);
        chk({tag, "_pulses"}, int'({bus.ld_pulse, bus.exec_pulse, bus.cmp_pulse}), 0);
        chk({tag, "_status"}, int'({busy, done, err}), 0);
        chk({tag, "_pc"}, int'(pc), 0);
    endtask

    logic [11:0] p1 [4];
    logic [2:0]  legal [5];

    initial begin
        p1[0] = 12'b001_001_000_000;
        p1[1] = 12'b001_010_001_000;
        p1[2] = 12'b010_011_001_010;
        p1[3] = 12'b000_000_000_000;
        legal[0] = 3'b001; legal[1] = 3'b010; legal[2] = 3'b011;
        legal[3] = 3'b101; legal[4] = 3'b110;
        bus.ack = 1'b1;

        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        check_all_zero("reset");

        // Three issued instructions then halt, ack tied high.
        for (int i = 0; i < 4; i++) load_word(i, p1[i]);
        push_instr(p1[0], 0, 0); push_instr(p1[1], 1, 5); push_instr(p1[2], 2, 5);
        push_end(1'b1, 1'b0, 3, 0);
        start_run();
        wait_idle(100);

        // Compare opcode then halt.
        load_word(0, 12'b101_000_010_011);
        load_word(1, 12'b000_000_000_000);
        push_instr(12'b101_000_010_011, 0, 0);
        push_end(1'b1, 1'b0, 1, 0);
        start_run();
        wait_idle(100);

        // Illegal opcode at address 2.
        load_word(0, p1[0]); load_word(1, p1[1]); load_word(2, 12'b111_001_001_001);
        push_instr(p1[0], 0, 0); push_instr(p1[1], 1, 5);
        push_end(1'b0, 1'b1, 2, 0);
        start_run();
        wait_idle(100);

        // Ack never arrives: error exactly TIMEOUT cycles after the execute strobe.
        load_word(0, 12'b011_001_010_011);
        load_word(1, 12'b000_000_000_000);
        bus.ack = 1'b0;
        push_instr(12'b011_001_010_011, 0, 0);
        push_end(1'b0, 1'b1, 0, 10);
        start_run();
        wait_idle(100);

        // Ack on the last allowed WAIT cycle wins over the timeout.
        push_instr(12'b011_001_010_011, 0, 0);
        push_end(1'b1, 1'b0, 1, 0);
        start_run();
        wait_fire(50);
        repeat (9) @(negedge CLOCK_50);
        bus.ack = 1'b1;
        @(negedge CLOCK_50);
        bus.ack = 1'b0;
        wait_idle(100);

        // Single-step: parks in PAUSE after each ack.
        for (int i = 0; i < 4; i++) load_word(i, p1[i]);
        bus.ack = 1'b1;
        step_mode = 1'b1;
        push_instr(p1[0], 0, 0); push_instr(p1[1], 1, 0); push_instr(p1[2], 2, 0);
        push_end(1'b1, 1'b0, 3, 0);
        start_run();
        for (int k = 0; k < 3; k++) begin
            int snap;
            wait_fire(50);
            @(negedge CLOCK_50);
            snap = n_pulse;
            repeat (6) @(negedge CLOCK_50);
            chk("pause_busy", int'(busy), 1);
            chk("pause_no_pulses", n_pulse, snap);
            step = 1'b1;
            @(negedge CLOCK_50);
            step = 1'b0;
        end
        wait_idle(100);
        step_mode = 1'b0;

        // Full-depth program with no halt word.
        for (int i = 0; i < 16; i++) begin
            logic [11:0] w;
            w = {legal[i % 5], 3'(i), 3'((i + 1) % 8), 3'((i + 3) % 8)};
            load_word(i, w);
            push_instr(w, i, (i == 0) ? 0 : 5);
        end
        push_end(1'b1, 1'b0, 15, 0);
        start_run();
        wait_idle(200);

        // Abort while waiting on the second instruction's ack.
        for (int i = 0; i < 4; i++) load_word(i, p1[i]);
        push_instr(p1[0], 0, 0); push_instr(p1[1], 1, 5);
        push_end(1'b0, 1'b0, 1, 0);
        start_run();
        wait_fire(50);
        wait_fire(50);
        bus.ack = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        abort = 1'b1;
        @(negedge CLOCK_50);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        wait_idle(10);
        bus.ack = 1'b1;

        // RESET while in LOAD, then the same program again.
        push_end(1'b0, 1'b0, 0, 0);
        start_run();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET = 1'b1;
        @(negedge CLOCK_50);
        RESET = 1'b0;
        check_all_zero("midreset");
        repeat (3) @(negedge CLOCK_50);
        chk("midreset_quiet", int'({bus.ld_pulse, bus.exec_pulse, busy}), 0);
        push_instr(p1[0], 0, 0); push_instr(p1[1], 1, 5); push_instr(p1[2], 2, 5);
        push_end(1'b1, 1'b0, 3, 0);
        start_run();
        wait_idle(100);

        repeat (5) @(negedge CLOCK_50);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
